store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; SHALL clear all state immediately when low.
REQ-004 st_valid  input  1  core presents a store this cycle.
REQ-005 st_addr  input  32  store byte address; only [31:2] is significant.
REQ-006 st_data  input  32  store word.
REQ-007 st_ready  output  1  buffer can accept a store; the core SHALL stall its M stage while st_valid=1 and st_ready=0.
REQ-008 ld_addr  input  32  address of the core's current load; only [31:2] is significant.
REQ-009 ld_valid  input  1  core presents a load this cycle.
REQ-010 ld_hit  output  1  a buffered store matches ld_addr.
REQ-011 ld_data  output  32  forwarded word; SHALL be valid when ld_hit=1, otherwise 0.
REQ-012 mem_write  output  1  write request to dmem.
REQ-013 mem_addr  output  32  dmem write address (head entry).
REQ-014 mem_write_data  output  32  dmem write data (head entry).
REQ-015 mem_ready  input  1  dmem accepts the write this cycle.
REQ-016 empty  output  1  no entries buffered.
REQ-017 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Push SHALL occur when st_valid=1 and st_ready=1; the entry SHALL be visible (count, ld_hit, mem_write) from the next cycle.
REQ-019 st_ready SHALL equal (count < DEPTH), using the registered count only; a pop in the same cycle SHALL NOT enable a push when full.
REQ-020 mem_write SHALL equal !empty; mem_addr and mem_write_data SHALL be the oldest entry and SHALL remain stable while mem_ready=0.
REQ-021 Pop SHALL occur when mem_write=1 and mem_ready=1; entries SHALL drain strictly in FIFO order, one per cycle maximum.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL saturate at neither bound (over/underflow prevented by REQ-019/REQ-020).
REQ-024 ld_hit SHALL be combinational: ld_valid=1 and any occupied entry with addr[31:2]==ld_addr[31:2].
REQ-025 When several entries match, ld_data SHALL come from the youngest matching entry.
REQ-026 A store being pushed in the same cycle SHALL NOT forward (no input bypass); the entry being popped in the same cycle SHALL still forward.
REQ-027 No store coalescing; duplicate addresses SHALL occupy separate entries.
REQ-028 Store address SHALL be recorded with [1:0] forced to 0.

Reset
REQ-029 While reset=0: pointers=0, count=0, empty=1, st_ready=1, mem_write=0, mem_addr=0, mem_write_data=0, ld_hit=0, ld_data=0; buffered stores SHALL be discarded, including one mid-handshake.
REQ-030 First push SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-031 Package sb_pkg SHALL hold SB_DEPTH default constant and typedef sb_entry_t {addr[31:2], data[31:0]}.
REQ-032 One sub-module, sb_match, SHALL implement the youngest-match priority select (entries, valid mask, head pointer, ld_addr -> hit, data).
REQ-033 Entry storage SHALL be flops, no reset required on data fields beyond REQ-029 outputs.

Verification
REQ-034 Reset, push 0x100/0xA5A5A5A5 with mem_ready=1 -> next cycle mem_write=1, mem_addr=0x100, mem_write_data=0xA5A5A5A5; empty=1 the cycle after.
REQ-035 mem_ready=0, push 4 stores -> count=4, st_ready=0; 5th st_valid held, not accepted; mem_ready=1 -> drains in order, 5th accepted cycle after first pop.
REQ-036 Push 0x40/0x11 then 0x40/0x22, load 0x42 -> ld_hit=1, ld_data=0x22; load 0x44 -> ld_hit=0, ld_data=0.
REQ-037 count=2, push and pop same cycle -> count stays 2; repeat 10 times -> pointer wrap, FIFO order preserved.
REQ-038 count=3, mem_ready=0, assert reset low mid-cycle -> outputs reach REQ-029 values without a clock edge; no dmem write after release.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and defaults for the store buffer.
package sb_pkg;

    // Default number of buffered stores (power of two, 2..16).
    localparam int unsigned SB_DEPTH = 4;

    // One buffered store; the word address keeps only bits [31:2].
    typedef struct packed {
        logic [31:2] addr;
        logic [31:0] data;
    } sb_entry_t;

endpackage : sb_pkg

// File: rtl/sb_match.sv
// Store-to-load forwarding select: youngest occupied entry whose word address matches.
module sb_match
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  sb_entry_t                    entries_i [DEPTH],
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [$clog2(DEPTH)-1:0]     head_i,
    input  logic [31:2]                  ld_addr_i,
    output logic                         hit_o,
    output logic [31:0]                  data_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk from oldest (head) to youngest; a later match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_i + PW'(i);
            if (valid_i[idx] && (entries_i[idx].addr == ld_addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule : sb_match

// File: rtl/store_buffer.sv
// In-order store buffer: queues core stores, drains them to dmem, forwards to loads.
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    output logic                       st_ready,
    input  logic [31:0]                ld_addr,
    input  logic                       ld_valid,
    output logic                       ld_hit,
    output logic [31:0]                ld_data,
    output logic                       mem_write,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_write_data,
    input  logic                       mem_ready,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t         entries_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    logic              push, pop;
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     age;
    logic              match_hit;
    logic [31:0]       match_data;

    // Byte-offset bits are architecturally ignored on both store and load addresses.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    // Handshakes use only registered occupancy, so a same-cycle pop never frees a full buffer.
    always_comb begin
        empty     = (count_q == '0);
        st_ready  = (count_q < CW'(DEPTH));
        mem_write = !empty;
        push      = st_valid && st_ready;
        pop       = mem_write && mem_ready;
        count     = count_q;
    end

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless until occupancy covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wr_ptr_q] <= '{addr: st_addr[31:2], data: st_data};
        end
    end

    // Occupancy mask: an entry is live if its distance from head is below count.
    always_comb begin
        valid = '0;
        age   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age      = PW'(i) - rd_ptr_q;
            valid[i] = ({1'b0, age} < count_q);
        end
    end

    sb_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entries_i (entries_q),
        .valid_i   (valid),
        .head_i    (rd_ptr_q),
        .ld_addr_i (ld_addr[31:2]),
        .hit_o     (match_hit),
        .data_o    (match_data)
    );

    // Forwarding and dmem outputs, forced to zero whenever nothing qualifies.
    always_comb begin
        ld_hit         = ld_valid && match_hit;
        ld_data        = ld_hit ? match_data : '0;
        mem_addr       = empty ? '0 : {entries_q[rd_ptr_q].addr, 2'b00};
        mem_write_data = empty ? '0 : entries_q[rd_ptr_q].data;
    end

endmodule : store_buffer
